// File: rtl/mac_operand_loader_if.sv
// Bus bundle for mac_operand_loader: Wishbone slave side, operand stream to the MAC, and the IRQ line.
interface mac_operand_loader_if #(
  parameter int DATA_W = 16
);
  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i;
  logic [31:0]       wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  // Stream handshake: a pair transfers on every rising edge where op_valid_o && op_ready_i; while
  // op_valid_o is high and op_ready_i low, op_a_o/op_b_o/op_last_o hold their values.
  logic              op_valid_o;
  logic              op_ready_i;
  logic [DATA_W-1:0] op_a_o;
  logic [DATA_W-1:0] op_b_o;
  logic              op_last_o;
  logic              irq_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, op_ready_i,
    output wbs_ack_o, wbs_dat_o, op_valid_o, op_a_o, op_b_o, op_last_o, irq_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, op_ready_i,
    input  wbs_ack_o, wbs_dat_o, op_valid_o, op_a_o, op_b_o, op_last_o, irq_o
  );
endinterface

// File: rtl/mac_operand_loader.sv
// Wishbone slave that buffers firmware-written operand pairs in a FWFT FIFO and streams them to the MAC.
module mac_operand_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          DATA_W    = 16,
  parameter int          DEPTH     = 8
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_ni,
  mac_operand_loader_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * DATA_W + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow, enable, ack;
  logic [31:0]   rdata, rd_mux;

  logic [1:0] reg_sel;
  logic       hit, wr, push_req, flush, empty, full, pop, do_push, do_pop, ovf_set, ovf_clr;
  logic       unused_bits;

  assign reg_sel  = bus.wbs_adr_i[3:2];
  assign hit      = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack &
                    (bus.wbs_adr_i[31:4] == ADDR_BASE[31:4]);
  assign wr       = hit & bus.wbs_we_i;
  assign push_req = wr & ~reg_sel[1];
  assign flush    = wr & (reg_sel == 2'd3) & bus.wbs_dat_i[1];
  assign empty    = (count == '0);
  // Full uses the registered count, so a pop on the same edge never frees a slot for a push.
  assign full     = (count == CW'(DEPTH));
  assign pop      = bus.op_valid_o & bus.op_ready_i;
  assign do_push  = push_req & ~full & ~flush;
  assign do_pop   = pop & ~flush;
  assign ovf_set  = push_req & full & ~flush;
  assign ovf_clr  = wr & (reg_sel == 2'd2) & bus.wbs_dat_i[18];

  assign unused_bits = ^{bus.wbs_sel_i, bus.wbs_adr_i[1:0], bus.wbs_dat_i};

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      2'd2: begin
        rd_mux[CW-1:0] = count;
        rd_mux[16]     = empty;
        rd_mux[17]     = full;
        rd_mux[18]     = overflow;
        rd_mux[19]     = enable;
      end
      2'd3:    rd_mux[0] = enable;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack      <= 1'b0;
      rdata    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      enable   <= 1'b0;
    end else begin
      ack   <= hit;
      rdata <= (hit & ~bus.wbs_we_i) ? rd_mux : 32'd0;
      if (wr && reg_sel == 2'd3) enable <= bus.wbs_dat_i[0];
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage carries no reset: contents are meaningless while count is zero.
  always_ff @(posedge wb_clk_i) begin
    if (do_push)
      mem[wr_ptr] <= {reg_sel[0], bus.wbs_dat_i[DATA_W-1:0], bus.wbs_dat_i[16 +: DATA_W]};
  end

  assign bus.wbs_ack_o  = ack;
  assign bus.wbs_dat_o  = rdata;
  assign bus.op_valid_o = ~empty & enable;
  assign bus.op_last_o  = mem[rd_ptr][EW-1];
  assign bus.op_a_o     = mem[rd_ptr][2*DATA_W-1:DATA_W];
  assign bus.op_b_o     = mem[rd_ptr][DATA_W-1:0];
  assign bus.irq_o      = overflow;
endmodule

// File: tb/tb_mac_operand_loader.sv
// Directed bench for mac_operand_loader: register table, streaming, overflow, flush, wrap and reset.
module tb_mac_operand_loader;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;
  logic [2*DW:0] exp_q[$];

  mac_operand_loader_if #(.DATA_W(DW)) bus ();

  mac_operand_loader #(.ADDR_BASE(BASE), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  reg_sel;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Inputs change only at posedge+1, so the negedge sees a stable handshake.
  always @(negedge clk) begin
    if (rst_n && bus.op_valid_o && bus.op_ready_i) begin
      pops++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got=0x%0h expected=none",
                 {bus.op_last_o, bus.op_a_o, bus.op_b_o});
      end else begin
        check("pop_data", {7'd0, bus.op_last_o, bus.op_a_o, bus.op_b_o}, {7'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wb_access(input logic we, input logic [1:0] r, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = BASE | {28'd0, r, 2'b00};
    bus.wbs_dat_i = wd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.wbs_ack_o && lat < 8);
    if (!bus.wbs_ack_o) check("wb_ack_timeout", 40'd0, 40'd1);
    rd = bus.wbs_dat_o;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] r, input logic [31:0] wd);
    logic [31:0] rd;
    int lat;
    wb_access(1'b1, r, wd, rd, lat);
  endtask

  task automatic wb_read(input logic [1:0] r, output logic [31:0] rd);
    int lat;
    wb_access(1'b0, r, 32'd0, rd, lat);
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    int seen;
    int wait_n;

    vecs[0] = '{1'b0, 2'd2, 32'h0,         32'h0001_0000};
    vecs[1] = '{1'b0, 2'd0, 32'h0,         32'h0};
    vecs[2] = '{1'b0, 2'd3, 32'h0,         32'h0};
    vecs[3] = '{1'b1, 2'd0, 32'h0003_0002, 32'h0};
    vecs[4] = '{1'b1, 2'd0, 32'h0003_0002, 32'h0};
    vecs[5] = '{1'b1, 2'd0, 32'h0003_0002, 32'h0};
    vecs[6] = '{1'b1, 2'd1, 32'h0005_0004, 32'h0};
    vecs[7] = '{1'b0, 2'd2, 32'h0,         32'h0000_0004};
    vecs[8] = '{1'b0, 2'd1, 32'h0,         32'h0};

    rst_n = 1'b0;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
    bus.op_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state and first read latency
    check("rst_ack", {39'd0, bus.wbs_ack_o}, 40'd0);
    check("rst_valid", {39'd0, bus.op_valid_o}, 40'd0);
    check("rst_irq", {39'd0, bus.irq_o}, 40'd0);
    wb_access(1'b0, 2'd2, 32'd0, rd, lat);
    check("rst_status", {8'd0, rd}, 40'h0001_0000);
    check("ack_latency", 40'(lat), 40'd1);

    // Address outside the block must never be acked
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = BASE + 32'h10;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) seen = 1;
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    check("miss_no_ack", 40'(seen), 40'd0);

    // Register table with enable=0: pushes buffer but nothing streams
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].we) begin
        wb_write(vecs[i].reg_sel, vecs[i].wdata);
        exp_q.push_back({vecs[i].reg_sel[0], vecs[i].wdata[DW-1:0], vecs[i].wdata[16 +: DW]});
      end else begin
        wb_read(vecs[i].reg_sel, rd);
        check($sformatf("table_rd%0d", i), {8'd0, rd}, {8'd0, vecs[i].exp});
      end
    end
    check("gated_valid", {39'd0, bus.op_valid_o}, 40'd0);

    // Enable with ready high: four back-to-back pairs
    bus.op_ready_i = 1'b1;
    wb_write(2'd3, 32'h1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stream_valid%0d", k), {39'd0, bus.op_valid_o}, 40'd1);
      @(posedge clk); #1;
    end
    check("stream_done_valid", {39'd0, bus.op_valid_o}, 40'd0);
    check("stream_q_empty", 40'(exp_q.size()), 40'd0);
    bus.op_ready_i = 1'b0;

    // Overflow: DEPTH+1 pushes with ready low
    for (int i = 0; i <= DEPTH; i++) begin
      wb_write(2'd0, {16'(i + 16), 16'(i)});
      if (i < DEPTH) exp_q.push_back({1'b0, 16'(i), 16'(i + 16)});
    end
    wb_read(2'd2, rd);
    check("ovf_status", {8'd0, rd}, 40'h000E_0008);
    check("ovf_irq", {39'd0, bus.irq_o}, 40'd1);
    wb_write(2'd2, 32'h0004_0000);
    check("ovf_clr_irq", {39'd0, bus.irq_o}, 40'd0);
    wb_read(2'd2, rd);
    check("ovf_clr_status", {8'd0, rd}, 40'h000A_0008);

    // Full FIFO: push on the same edge as a pop is still dropped
    @(posedge clk); #1;
    bus.op_ready_i = 1'b1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = BASE; bus.wbs_dat_i = 32'h00AA_00BB;
    @(posedge clk); #1;
    check("samecyc_ack", {39'd0, bus.wbs_ack_o}, 40'd1);
    bus.op_ready_i = 1'b0;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    check("samecyc_irq", {39'd0, bus.irq_o}, 40'd1);
    wb_read(2'd2, rd);
    check("samecyc_status", {8'd0, rd}, 40'h000C_0007);
    wb_write(2'd2, 32'h0004_0000);
    wb_write(2'd3, 32'h3);
    exp_q.delete();

    // Flush with five entries queued
    for (int i = 0; i < 5; i++) wb_write(2'd0, 32'h0001_0001);
    wb_read(2'd2, rd);
    check("pre_flush_status", {8'd0, rd}, 40'h0008_0005);
    wb_write(2'd3, 32'h3);
    check("flush_valid", {39'd0, bus.op_valid_o}, 40'd0);
    wb_read(2'd3, rd);
    check("flush_ctrl", {8'd0, rd}, 40'h1);
    wb_read(2'd2, rd);
    check("flush_status", {8'd0, rd}, 40'h0009_0000);

    // Wrap: 3*DEPTH pairs with random ready, writer backs off while full
    pops = 0;
    seen = 0;
    fork
      begin
        for (int i = 0; i < 3 * DEPTH; i++) begin
          wait_n = 0;
          do begin
            wb_read(2'd2, rd);
            wait_n++;
          end while (rd[17] && wait_n < 50);
          wb_write((i % 4 == 3) ? 2'd1 : 2'd0, {~16'(i), 16'(i)});
          exp_q.push_back({(i % 4 == 3) ? 1'b1 : 1'b0, 16'(i), ~16'(i)});
        end
        seen = 1;
      end
      begin
        while (seen == 0) begin
          @(posedge clk); #1;
          bus.op_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.op_ready_i = 1'b1;
    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 200) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("wrap_drained", 40'(exp_q.size()), 40'd0);
    check("wrap_pops", 40'(pops), 40'(3 * DEPTH));

    // Asynchronous reset while pairs are queued
    bus.op_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) wb_write(2'd0, 32'h0007_0006);
    check("pre_rst_valid", {39'd0, bus.op_valid_o}, 40'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {39'd0, bus.op_valid_o}, 40'd0);
    check("midrst_irq", {39'd0, bus.irq_o}, 40'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    wb_read(2'd2, rd);
    check("midrst_status", {8'd0, rd}, 40'h0001_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
